// File: rtl/data_memory_stage.sv
// Memory-access stage: word-addressed data RAM with fixed wait states, a stall output that
// freezes the datapath for the duration of each access, and a sticky illegal-access flag.
module data_memory_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h10010000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        busy,
    output logic        err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_END = ADDR_BASE + 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_next;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic             r_rd;
    logic             r_wr;
    logic             r_legal;
    logic [31:0]      r_readdata;
    logic             r_err;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_req;
    logic             w_legal;
    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic             w_enter_done;
    logic             w_rd_sel;
    logic             w_legal_sel;
    logic [IDX_W-1:0] w_idx_sel;

    assign w_req    = memread | memwrite;
    assign w_offset = addr - ADDR_BASE;
    assign w_idx    = IDX_W'(w_offset >> 2);
    assign w_legal  = (memread ^ memwrite) && (addr[1:0] == 2'b00) &&
                      (addr >= ADDR_BASE) && (addr < ADDR_END);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    stall        = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_state_next = (WAIT_CYCLES == 1) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall      = 1'b1;
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (reset) begin
            stall = 1'b0;
        end
    end

    // With a single wait state DONE is entered straight from IDLE, before the latches hold the
    // request, so the read source must come from the live inputs in that case.
    assign w_enter_done = (w_state_next == ST_DONE) && (r_state != ST_DONE);
    assign w_rd_sel     = (r_state == ST_IDLE) ? memread : r_rd;
    assign w_legal_sel  = (r_state == ST_IDLE) ? w_legal : r_legal;
    assign w_idx_sel    = (r_state == ST_IDLE) ? w_idx   : r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_readdata <= 32'h0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'h0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_legal    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if ((r_state == ST_IDLE) && w_req) begin
                r_idx   <= w_idx;
                r_wdata <= writedata;
                r_rd    <= memread;
                r_wr    <= memwrite;
                r_legal <= w_legal;
                if (!w_legal) begin
                    r_err <= 1'b1;
                end
            end
            if (w_enter_done && w_rd_sel) begin
                r_readdata <= w_legal_sel ? r_mem[w_idx_sel] : 32'h0;
            end
        end
    end

    // Stores commit as DONE ends; a reset in DONE drops the pending store.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_DONE) && r_wr && r_legal) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign readdata = r_readdata;
    assign busy     = (r_state != ST_IDLE);
    assign err      = r_err;

endmodule
